// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Sole owner of a byte-wide RAM port. It shares the port between the
// instruction-fetch stage (word reads only) and the MEM stage (byte/half/word
// loads and stores). Each request becomes a little-endian run of single-byte
// RAM accesses. Read bytes are assembled into a word, and completion is
// signalled with a one-cycle done pulse.
//
// Handshake: a requester raises req together with its operands and holds all
// of them stable until its done pulse. It drops req no later than the cycle
// after done, because a req that is still high in IDLE counts as a new
// request. Requests are sampled only in IDLE, so there is no preemption.
//
// Ports
//   clk          system clock; all state changes on the rising edge
//   rst          asynchronous active-low reset
//   if_req_i     IF requests a 4-byte read at if_addr_i
//   if_addr_i    IF byte address
//   if_done_o    one-cycle pulse; if_rdata_o is valid
//   if_rdata_o   assembled instruction word
//   mem_req_i    MEM requests an access
//   mem_we_i     1 = store, 0 = load
//   mem_size_i   0 = 1 byte, 1 = 2 bytes, 2/3 = 4 bytes
//   mem_addr_i   MEM byte address
//   mem_wdata_i  store data; byte i = bits [8i+7:8i]
//   mem_done_o   one-cycle pulse; MEM transaction complete
//   mem_rdata_o  load data, raw bytes zero-extended
//   ram_addr_o   RAM byte address
//   ram_we_o     RAM write enable for the current byte
//   ram_wdata_o  RAM write byte
//   ram_rdata_i  RAM read byte, valid one cycle after its address
//   busy_o       high whenever the FSM is not in IDLE
//   state_o      debug view of the FSM state (0 IDLE, 1 READ, 2 WRITE, 3 DONE)
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter bit MEM_PRIORITY = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    output logic                  if_done_o,
    output logic [31:0]           if_rdata_o,
    input  logic                  mem_req_i,
    input  logic                  mem_we_i,
    input  logic [1:0]            mem_size_i,
    input  logic [ADDR_WIDTH-1:0] mem_addr_i,
    input  logic [31:0]           mem_wdata_i,
    output logic                  mem_done_o,
    output logic [31:0]           mem_rdata_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic                  ram_we_o,
    output logic [7:0]            ram_wdata_o,
    input  logic [7:0]            ram_rdata_i,
    output logic                  busy_o,
    output logic [1:0]            state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                state;
    logic                  owner_mem;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [2:0]            len;
    // step = index of the current cycle within the transaction (grant cycle = 0)
    logic [2:0]            step;
    logic [31:0]           wdata_q;
    logic [31:0]           rbuf;

    logic                  grant_mem;
    logic                  grant_if;
    logic [ADDR_WIDTH-1:0] grant_addr;
    logic [2:0]            req_len;
    logic [1:0]            byte_idx;
    logic [31:0]           rd_merged;

    assign state_o = state;

    always_comb begin
        grant_mem  = mem_req_i && (MEM_PRIORITY || !if_req_i);
        grant_if   = if_req_i && !grant_mem;
        grant_addr = grant_mem ? mem_addr_i : if_addr_i;
        case (mem_size_i)
            2'd0:    req_len = 3'd1;
            2'd1:    req_len = 3'd2;
            default: req_len = 3'd4;
        endcase
    end

    // In cycle k (k >= 2), RAM returns the byte addressed in cycle k-1. That is
    // byte k-2 of the word. Merging it combinationally lets the final byte go
    // straight into the registered rdata output on the edge that enters DONE.
    always_comb begin
        byte_idx                        = step[1:0] - 2'd2;
        rd_merged                       = rbuf;
        rd_merged[{byte_idx, 3'b000} +: 8] = ram_rdata_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            owner_mem   <= 1'b0;
            next_addr   <= '0;
            len         <= '0;
            step        <= '0;
            wdata_q     <= '0;
            rbuf        <= '0;
            if_done_o   <= 1'b0;
            if_rdata_o  <= '0;
            mem_done_o  <= 1'b0;
            mem_rdata_o <= '0;
            ram_addr_o  <= '0;
            ram_we_o    <= 1'b0;
            ram_wdata_o <= '0;
            busy_o      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if_done_o   <= 1'b0;
                    mem_done_o  <= 1'b0;
                    ram_we_o    <= 1'b0;
                    ram_addr_o  <= '0;
                    ram_wdata_o <= '0;
                    if (grant_mem || grant_if) begin
                        owner_mem  <= grant_mem;
                        len        <= grant_mem ? req_len : 3'd4;
                        wdata_q    <= mem_wdata_i;
                        rbuf       <= '0;
                        step       <= 3'd1;
                        busy_o     <= 1'b1;
                        ram_addr_o <= grant_addr;
                        next_addr  <= grant_addr + ADDR_ONE;
                        if (grant_mem && mem_we_i) begin
                            state       <= WRITE;
                            ram_we_o    <= 1'b1;
                            ram_wdata_o <= mem_wdata_i[7:0];
                        end else begin
                            state <= READ;
                        end
                    end else begin
                        busy_o <= 1'b0;
                    end
                end

                READ: begin
                    if (step >= 3'd2) begin
                        rbuf <= rd_merged;
                    end
                    if (step < len) begin
                        ram_addr_o <= next_addr;
                        next_addr  <= next_addr + ADDR_ONE;
                        step       <= step + 3'd1;
                    end else if (step == len) begin
                        // Last address was presented; wait one cycle for its byte.
                        ram_addr_o <= '0;
                        step       <= step + 3'd1;
                    end else begin
                        state <= DONE;
                        if (owner_mem) begin
                            mem_done_o  <= 1'b1;
                            mem_rdata_o <= rd_merged;
                        end else begin
                            if_done_o  <= 1'b1;
                            if_rdata_o <= rd_merged;
                        end
                    end
                end

                WRITE: begin
                    if (step < len) begin
                        ram_addr_o  <= next_addr;
                        next_addr   <= next_addr + ADDR_ONE;
                        ram_wdata_o <= wdata_q[{step[1:0], 3'b000} +: 8];
                        step        <= step + 3'd1;
                    end else begin
                        ram_we_o    <= 1'b0;
                        ram_addr_o  <= '0;
                        ram_wdata_o <= '0;
                        mem_done_o  <= 1'b1;
                        state       <= DONE;
                    end
                end

                DONE: begin
                    if_done_o  <= 1'b0;
                    mem_done_o <= 1'b0;
                    busy_o     <= 1'b0;
                    state      <= IDLE;
                end

                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
